// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the memory-side arbiters (read path now, write path later).
//   rd_arb_state_e : read arbiter FSM states
//   ID_ICACHE/ID_DCACHE : AXI IDs used to tag each requester's transactions
//   BURST_INCR : AXI INCR burst encoding
//   owner_id() : AXI ID owning the bus in a given read-arbiter state
package mem_arb_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StArI  = 3'd1,
    StArD  = 3'd2,
    StRI   = 3'd3,
    StRD   = 3'd4
  } rd_arb_state_e;

  localparam logic [3:0] ID_ICACHE  = 4'd0;
  localparam logic [3:0] ID_DCACHE  = 4'd1;
  localparam logic [1:0] BURST_INCR = 2'b01;

  function automatic logic [3:0] owner_id(rd_arb_state_e st);
    return ((st == StArD) || (st == StRD)) ? ID_DCACHE : ID_ICACHE;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// Signal bundle for axi_rd_arbiter: two cache-side AR/R requester ports (i_*, d_*) and the
// shared AXI read channel (AR/R) toward the top-level master port.
//   modport master : the arbiter's view (drives the bus AR fields and cache-side returns)
//   modport slave  : the environment's view (caches plus AXI slave)
interface axi_rd_arbiter_if;

  // i_cache requester
  logic [31:0] i_araddr;
  logic [7:0]  i_arlen;
  logic [2:0]  i_arsize;
  logic        i_arvalid;
  logic        i_arready;
  logic [31:0] i_rdata;
  logic        i_rlast;
  logic        i_rvalid;
  logic        i_rready;

  // d_cache requester
  logic [31:0] d_araddr;
  logic [7:0]  d_arlen;
  logic [2:0]  d_arsize;
  logic        d_arvalid;
  logic        d_arready;
  logic [31:0] d_rdata;
  logic        d_rlast;
  logic        d_rvalid;
  logic        d_rready;

  // AXI read channel
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  // Sticky protocol error flag
  logic        rid_err;

  modport master (
    input  i_araddr, i_arlen, i_arsize, i_arvalid, i_rready,
    output i_arready, i_rdata, i_rlast, i_rvalid,
    input  d_araddr, d_arlen, d_arsize, d_arvalid, d_rready,
    output d_arready, d_rdata, d_rlast, d_rvalid,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output rid_err
  );

  modport slave (
    output i_araddr, i_arlen, i_arsize, i_arvalid, i_rready,
    input  i_arready, i_rdata, i_rlast, i_rvalid,
    output d_araddr, d_arlen, d_arsize, d_arvalid, d_rready,
    input  d_arready, d_rdata, d_rlast, d_rvalid,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  rid_err
  );

endinterface

// File: rtl/axi_rd_arbiter_starve_counter.sv
// starve_counter: saturating wait counter used to force fairness in the cache arbiters.
//   clk, rst : clock, synchronous active-high reset
//   inc_i    : count one more waiting cycle (saturates at all-ones)
//   clr_i    : clear the count; wins over inc_i
//   cnt_o    : current count
//   hit_o    : count has reached Limit
module starve_counter #(
  parameter int unsigned Limit = 8,
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [Width-1:0] cnt_o,
  output logic             hit_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign hit_o = (cnt_q >= Width'(Limit));

endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares the core's single AXI read channel between i_cache and d_cache.
// d_cache wins by default; i_cache is forced through once it has waited STARVE_LIMIT cycles.
// The grant is locked from the AR handshake until the final R beat; at most one read is in
// flight and every burst is followed by at least one idle arbitration cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : requester and AXI read-channel signals (see axi_rd_arbiter_if)
// STARVE_LIMIT must be below 2**CNT_W.
module axi_rd_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  axi_rd_arbiter_if.master bus
);

  rd_arb_state_e    state_q, state_d;
  logic             rid_err_q, rid_err_d;
  logic [CNT_W-1:0] starve_cnt;
  logic             starve_hit;
  logic             starve_inc;
  logic             starve_clr;

  // Response status is not propagated to the caches.
  logic unused_rresp;
  assign unused_rresp = ^bus.rresp;

  // Count is kept visible for debug; the decision only needs the hit flag.
  logic unused_starve_cnt;
  assign unused_starve_cnt = ^starve_cnt;

  // ---------------------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      rid_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rid_err_q <= rid_err_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.d_arvalid && !(bus.i_arvalid && starve_hit)) begin
          state_d = StArD;
        end else if (bus.i_arvalid) begin
          state_d = StArI;
        end
      end
      StArI: begin
        // A withdrawn request returns to arbitration without issuing anything.
        if (!bus.i_arvalid) begin
          state_d = StIdle;
        end else if (bus.arready) begin
          state_d = StRI;
        end
      end
      StArD: begin
        if (!bus.d_arvalid) begin
          state_d = StIdle;
        end else if (bus.arready) begin
          state_d = StRD;
        end
      end
      StRI: begin
        if (bus.rvalid && bus.i_rready && bus.rlast) begin
          state_d = StIdle;
        end
      end
      StRD: begin
        if (bus.rvalid && bus.d_rready && bus.rlast) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------------------
  always_comb begin
    bus.arvalid   = 1'b0;
    bus.arid      = owner_id(state_q);
    bus.araddr    = '0;
    bus.arlen     = '0;
    bus.arsize    = '0;
    bus.i_arready = 1'b0;
    bus.d_arready = 1'b0;
    bus.rready    = 1'b0;
    bus.i_rvalid  = 1'b0;
    bus.d_rvalid  = 1'b0;
    bus.i_rlast   = 1'b0;
    bus.d_rlast   = 1'b0;
    // Data is qualified by the per-requester valids, so it needs no mux.
    bus.i_rdata   = bus.rdata;
    bus.d_rdata   = bus.rdata;
    unique case (state_q)
      StArI: begin
        bus.arvalid   = bus.i_arvalid;
        bus.araddr    = bus.i_araddr;
        bus.arlen     = bus.i_arlen;
        bus.arsize    = bus.i_arsize;
        bus.i_arready = bus.arready;
      end
      StArD: begin
        bus.arvalid   = bus.d_arvalid;
        bus.araddr    = bus.d_araddr;
        bus.arlen     = bus.d_arlen;
        bus.arsize    = bus.d_arsize;
        bus.d_arready = bus.arready;
      end
      StRI: begin
        bus.i_rvalid = bus.rvalid;
        bus.i_rlast  = bus.rlast;
        bus.rready   = bus.i_rready;
      end
      StRD: begin
        bus.d_rvalid = bus.rvalid;
        bus.d_rlast  = bus.rlast;
        bus.rready   = bus.d_rready;
      end
      default: ;
    endcase
  end

  assign bus.arburst = BURST_INCR;
  assign bus.arlock  = '0;
  assign bus.arcache = '0;
  assign bus.arprot  = '0;
  assign bus.rid_err = rid_err_q;

  // A beat tagged for the wrong requester is still delivered; only the flag records it.
  always_comb begin
    rid_err_d = rid_err_q;
    if (((state_q == StRI) || (state_q == StRD)) && bus.rvalid &&
        (bus.rid != owner_id(state_q))) begin
      rid_err_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------------------
  // i_cache starvation tracking
  // ---------------------------------------------------------------------------------------
  always_comb begin
    starve_inc = bus.i_arvalid && !((state_q == StArI) || (state_q == StRI));
    starve_clr = (state_q == StIdle) && (state_d == StArI);
  end

  starve_counter #(
    .Limit(STARVE_LIMIT),
    .Width(CNT_W)
  ) u_starve_counter (
    .clk  (clk),
    .rst  (rst),
    .inc_i(starve_inc),
    .clr_i(starve_clr),
    .cnt_o(starve_cnt),
    .hit_o(starve_hit)
  );

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed cache requests against a small AXI slave responder,
// a per-cycle reference model of the arbitration rules, and literal timing expectations.
module tb_axi_rd_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_rd_arbiter_if bus_if ();

  axi_rd_arbiter #(
    .STARVE_LIMIT(8),
    .CNT_W       (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------------------
  // AXI slave responder: returns arlen+1 beats back-to-back after each AR handshake.
  // rid_flip corrupts the returned ID to provoke rid_err.
  // ---------------------------------------------------------------------------------------
  bit rid_flip = 1'b0;

  initial begin : responder
    int          pend;
    int          beat;
    int          burst;
    logic [3:0]  rsp_id;
    bit          s_rst, s_hs, s_beat;
    logic [7:0]  s_len;
    logic [3:0]  s_id;
    pend = 0; beat = 0; burst = 0; rsp_id = 4'd0;
    bus_if.rvalid = 1'b0;
    bus_if.rlast  = 1'b0;
    bus_if.rid    = 4'd0;
    bus_if.rdata  = 32'd0;
    bus_if.rresp  = 2'd0;
    forever begin
      @(negedge clk);
      s_rst  = rst;
      s_hs   = bus_if.arvalid && bus_if.arready;
      s_beat = bus_if.rvalid && bus_if.rready;
      s_len  = bus_if.arlen;
      s_id   = bus_if.arid;
      @(posedge clk);
      #1;
      if (s_rst) begin
        pend = 0;
      end else if (s_hs) begin
        pend   = int'(s_len) + 1;
        rsp_id = s_id ^ {3'b000, rid_flip};
        beat   = 0;
        burst++;
      end else if (s_beat) begin
        pend--;
        beat++;
      end
      bus_if.rvalid = (pend > 0);
      bus_if.rlast  = (pend == 1);
      bus_if.rid    = rsp_id;
      bus_if.rdata  = 32'hA500_0000 | (32'(burst & 255) << 8) | 32'(beat & 255);
    end
  end

  // ---------------------------------------------------------------------------------------
  // Reference model: who owns the channel (none / i / d) and in which phase (arbitrate,
  // address, data), plus the i_cache wait count. Checked on every falling edge.
  // ---------------------------------------------------------------------------------------
  int m_own = 0;     // 0 none, 1 i_cache, 2 d_cache
  int m_phase = 0;   // 0 arbitrate, 1 address, 2 data
  int m_starve = 0;
  bit m_err = 1'b0;

  int cyc = 0;
  int i_beats = 0, d_beats = 0, i_lasts = 0, d_lasts = 0;
  int nb_i = 0, nb_d = 0;
  int last_rlast_cyc = 0;
  int ar_id_q[$];
  int ar_cyc_q[$];

  bit a_i, a_d, r_i, r_d, i_wait, grant_i;
  logic e_arvalid, e_rready;

  always @(negedge clk) begin
    cyc++;
    a_i = (m_phase == 1) && (m_own == 1);
    a_d = (m_phase == 1) && (m_own == 2);
    r_i = (m_phase == 2) && (m_own == 1);
    r_d = (m_phase == 2) && (m_own == 2);
    e_arvalid = a_i ? bus_if.i_arvalid : (a_d ? bus_if.d_arvalid : 1'b0);
    e_rready  = r_i ? bus_if.i_rready  : (r_d ? bus_if.d_rready  : 1'b0);

    chk("arvalid",    bus_if.arvalid,   e_arvalid);
    chk("i_arready",  bus_if.i_arready, a_i ? bus_if.arready : 1'b0);
    chk("d_arready",  bus_if.d_arready, a_d ? bus_if.arready : 1'b0);
    chk("rready",     bus_if.rready,    e_rready);
    chk("i_rvalid",   bus_if.i_rvalid,  r_i ? bus_if.rvalid : 1'b0);
    chk("d_rvalid",   bus_if.d_rvalid,  r_d ? bus_if.rvalid : 1'b0);
    chk("rid_err",    bus_if.rid_err,   m_err);
    chk("starve_cnt", dut.starve_cnt,   m_starve);
    if (e_arvalid) begin
      chk("arid",    bus_if.arid,    a_i ? 0 : 1);
      chk("araddr",  bus_if.araddr,  a_i ? bus_if.i_araddr : bus_if.d_araddr);
      chk("arlen",   bus_if.arlen,   a_i ? bus_if.i_arlen  : bus_if.d_arlen);
      chk("arsize",  bus_if.arsize,  a_i ? bus_if.i_arsize : bus_if.d_arsize);
      chk("arburst", bus_if.arburst, 2'b01);
      chk("arlock",  bus_if.arlock,  2'b00);
      chk("arcache", bus_if.arcache, 4'd0);
      chk("arprot",  bus_if.arprot,  3'd0);
    end
    if (r_i && bus_if.rvalid) begin
      chk("i_rdata", bus_if.i_rdata, bus_if.rdata);
      chk("i_rlast", bus_if.i_rlast, bus_if.rlast);
    end
    if (r_d && bus_if.rvalid) begin
      chk("d_rdata", bus_if.d_rdata, bus_if.rdata);
      chk("d_rlast", bus_if.d_rlast, bus_if.rlast);
    end
    if (m_phase != 2) begin
      chk("i_rlast_idle", bus_if.i_rlast, 1'b0);
      chk("d_rlast_idle", bus_if.d_rlast, 1'b0);
    end

    // Scoreboard of what the caches actually received
    if (bus_if.arvalid && bus_if.arready) begin
      ar_id_q.push_back(int'(bus_if.arid));
      ar_cyc_q.push_back(cyc);
    end
    if (bus_if.i_rvalid && bus_if.i_rready) begin
      i_beats++;
      chk("i_beat_order", bus_if.i_rdata[7:0], nb_i);
      if (bus_if.i_rlast) begin
        i_lasts++; nb_i = 0; last_rlast_cyc = cyc;
      end else begin
        nb_i++;
      end
    end
    if (bus_if.d_rvalid && bus_if.d_rready) begin
      d_beats++;
      chk("d_beat_order", bus_if.d_rdata[7:0], nb_d);
      if (bus_if.d_rlast) begin
        d_lasts++; nb_d = 0; last_rlast_cyc = cyc;
      end else begin
        nb_d++;
      end
    end

    // Model advance for the coming clock edge
    if (rst) begin
      m_own = 0; m_phase = 0; m_starve = 0; m_err = 1'b0; nb_i = 0; nb_d = 0;
    end else begin
      i_wait  = bus_if.i_arvalid && !((m_own == 1) && (m_phase != 0));
      grant_i = 1'b0;
      if ((m_phase == 2) && bus_if.rvalid && (int'(bus_if.rid) != ((m_own == 1) ? 0 : 1)))
        m_err = 1'b1;
      case (m_phase)
        0: begin
          if (bus_if.d_arvalid && !(bus_if.i_arvalid && (m_starve >= 8))) begin
            m_own = 2; m_phase = 1;
          end else if (bus_if.i_arvalid) begin
            m_own = 1; m_phase = 1; grant_i = 1'b1;
          end
        end
        1: begin
          if (!e_arvalid) begin
            m_own = 0; m_phase = 0;
          end else if (bus_if.arready) begin
            m_phase = 2;
          end
        end
        default: begin
          if (bus_if.rvalid && e_rready && bus_if.rlast) begin
            m_own = 0; m_phase = 0;
          end
        end
      endcase
      if (grant_i) m_starve = 0;
      else if (i_wait && (m_starve < 15)) m_starve++;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.i_arvalid = 1'b0;
    bus_if.d_arvalid = 1'b0;
    step(2);
    rst = 1'b0;
    rid_flip = 1'b0;
    i_beats = 0; d_beats = 0; i_lasts = 0; d_lasts = 0;
    ar_id_q.delete();
    ar_cyc_q.delete();
  endtask

  // Waits for an AR handshake of the given requester, then withdraws that request.
  task automatic wait_ar(input bit is_d, input string name);
    int k;
    k = 0;
    while (!(bus_if.arvalid && (is_d ? bus_if.d_arready : bus_if.i_arready)) && (k < 60)) begin
      step();
      k++;
    end
    chk({name, "_ar_seen"}, (k < 60), 1'b1);
    step();
    if (is_d) bus_if.d_arvalid = 1'b0;
    else      bus_if.i_arvalid = 1'b0;
  endtask

  task automatic wait_beats(input bit is_d, input int n, input string name);
    int k;
    k = 0;
    while (((is_d ? d_beats : i_beats) < n) && (k < 60)) begin
      step();
      k++;
    end
    chk({name, "_beats"}, is_d ? d_beats : i_beats, n);
  endtask

  int n_d_first;

  initial begin : stim
    bus_if.i_araddr = '0; bus_if.i_arlen = '0; bus_if.i_arsize = 3'd2;
    bus_if.i_arvalid = 1'b0; bus_if.i_rready = 1'b1;
    bus_if.d_araddr = '0; bus_if.d_arlen = '0; bus_if.d_arsize = 3'd2;
    bus_if.d_arvalid = 1'b0; bus_if.d_rready = 1'b1;
    bus_if.arready = 1'b1;

    // 1: single i_cache burst of 4 beats
    do_reset();
    chk("rst_arvalid", bus_if.arvalid, 1'b0);
    chk("rst_rready", bus_if.rready, 1'b0);
    bus_if.i_araddr = 32'h1fc0_0000;
    bus_if.i_arlen  = 8'd3;
    bus_if.i_arvalid = 1'b1;
    wait_ar(1'b0, "t1");
    chk("t1_arid", ar_id_q.size() > 0 ? ar_id_q[0] : 99, 0);
    wait_beats(1'b0, 4, "t1");
    chk("t1_lasts", i_lasts, 1);
    chk("t1_last_latency", last_rlast_cyc - (ar_cyc_q.size() > 0 ? ar_cyc_q[0] : 0), 4);
    step();
    chk("t1_idle_arvalid", bus_if.arvalid, 1'b0);
    chk("t1_idle_i_rvalid", bus_if.i_rvalid, 1'b0);

    // 2: simultaneous requests, d_cache first, i_cache one idle cycle after d rlast
    do_reset();
    bus_if.i_araddr = 32'h0000_0100; bus_if.i_arlen = 8'd0;
    bus_if.d_araddr = 32'h0000_2000; bus_if.d_arlen = 8'd3;
    bus_if.i_arvalid = 1'b1;
    bus_if.d_arvalid = 1'b1;
    wait_ar(1'b1, "t2d");
    wait_ar(1'b0, "t2i");
    chk("t2_first_id", ar_id_q.size() > 1 ? ar_id_q[0] : 99, 1);
    chk("t2_second_id", ar_id_q.size() > 1 ? ar_id_q[1] : 99, 0);
    chk("t2_gap", (ar_cyc_q.size() > 1 ? ar_cyc_q[1] : 0) - last_rlast_cyc, 2);
    chk("t2_d_beats", d_beats, 4);
    wait_beats(1'b0, 1, "t2i");

    // 3: starvation with d_cache single-beat bursts held back-to-back
    do_reset();
    bus_if.i_arlen = 8'd0; bus_if.d_arlen = 8'd0;
    bus_if.i_arvalid = 1'b1;
    bus_if.d_arvalid = 1'b1;
    wait_ar(1'b0, "t3i");
    n_d_first = 0;
    foreach (ar_id_q[k]) if ((ar_id_q[k] == 1) && (n_d_first == k)) n_d_first++;
    chk("t3_d_grants_before_i", n_d_first, 3);
    chk("t3_i_grant_cycle", (ar_cyc_q.size() > 3) ? ar_cyc_q[3] - ar_cyc_q[0] : 0, 9);
    wait_beats(1'b0, 1, "t3i");
    bus_if.d_arvalid = 1'b0;
    step(4);

    // 4: d_cache backpressure 1,0,1,0...
    do_reset();
    bus_if.d_arlen = 8'd3;
    bus_if.d_rready = 1'b1;
    bus_if.d_arvalid = 1'b1;
    wait_ar(1'b1, "t4");
    for (int k = 0; (k < 40) && (d_beats < 4); k++) begin
      bus_if.d_rready = ~bus_if.d_rready;
      step();
    end
    bus_if.d_rready = 1'b1;
    chk("t4_d_beats", d_beats, 4);
    chk("t4_d_lasts", d_lasts, 1);
    chk("t4_i_beats", i_beats, 0);
    step(2);

    // 5: reset in the middle of a d_cache burst carrying a bad ID while i_cache waits
    do_reset();
    rid_flip = 1'b1;
    bus_if.d_arlen = 8'd3;
    bus_if.i_arvalid = 1'b1;
    bus_if.d_arvalid = 1'b1;
    wait_ar(1'b1, "t5");
    wait_beats(1'b1, 2, "t5");
    chk("t5_rid_err_set", bus_if.rid_err, 1'b1);
    rst = 1'b1;
    bus_if.i_arvalid = 1'b0;
    step();
    chk("t5_arvalid", bus_if.arvalid, 1'b0);
    chk("t5_rready", bus_if.rready, 1'b0);
    chk("t5_rid_err", bus_if.rid_err, 1'b0);
    chk("t5_starve", dut.starve_cnt, 4'd0);
    chk("t5_d_rvalid", bus_if.d_rvalid, 1'b0);
    rst = 1'b0;
    rid_flip = 1'b0;
    step(3);

    // 6a: withdrawn i_cache request
    do_reset();
    bus_if.arready = 1'b0;
    bus_if.i_arlen = 8'd1;
    bus_if.i_arvalid = 1'b1;
    step();
    chk("t6_arvalid_up", bus_if.arvalid, 1'b1);
    step();
    bus_if.i_arvalid = 1'b0;
    #1;
    chk("t6_arvalid_drop", bus_if.arvalid, 1'b0);
    step(2);
    chk("t6_no_ar", ar_id_q.size(), 0);
    chk("t6_idle_arvalid", bus_if.arvalid, 1'b0);

    // 6b: wrong rid during an i_cache burst; flag sticks until reset
    bus_if.arready = 1'b1;
    rid_flip = 1'b1;
    bus_if.i_arvalid = 1'b1;
    wait_ar(1'b0, "t6b");
    wait_beats(1'b0, 2, "t6b");
    chk("t6_rid_err", bus_if.rid_err, 1'b1);
    step(5);
    chk("t6_rid_err_sticky", bus_if.rid_err, 1'b1);
    do_reset();
    chk("t6_rid_err_clr", bus_if.rid_err, 1'b0);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the single AXI read channel (AR/R) of the core between the i_cache and d_cache refill/uncached read requesters.
- Default policy is d_cache priority, with an anti-starvation override for i_cache.
- The grant is locked from the AR handshake until the final beat (rlast) of the burst.
- Sits between the caches and the top-level AXI master port, replacing ad-hoc read muxing in the bridge.

Parameters:
- STARVE_LIMIT, 8: consecutive cycles i_cache may wait while d_cache wins before i_cache is forced to win.
- CNT_W, 4: width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- i_araddr  in  32  i_cache read address
- i_arlen  in  8  i_cache burst length-1
- i_arsize  in  3  i_cache beat size
- i_arvalid  in  1  i_cache AR request
- i_arready  out  1  AR accepted for i_cache
- i_rdata  out  32  read data to i_cache
- i_rlast  out  1  last beat to i_cache
- i_rvalid  out  1  beat valid to i_cache
- i_rready  in  1  i_cache beat accept
- d_araddr/d_arlen/d_arsize/d_arvalid  in  32/8/3/1  d_cache AR request (same meaning as i_*)
- d_arready  out  1  AR accepted for d_cache
- d_rdata/d_rlast/d_rvalid  out  32/1/1  d_cache read return
- d_rready  in  1  d_cache beat accept
- arid  out  4  4'd0 = i_cache, 4'd1 = d_cache
- araddr/arlen/arsize  out  32/8/3  muxed AR fields
- arburst  out  2  constant 2'b01 (INCR)
- arlock  out  2  constant 0
- arcache  out  4  constant 0
- arprot  out  3  constant 0
- arvalid  out  1  AR valid to bus
- arready  in  1  bus AR ready
- rid  in  4  returned ID
- rdata  in  32  returned data
- rresp  in  2  response (ignored)
- rlast  in  1  last beat
- rvalid  in  1  beat valid
- rready  out  1  beat accept to bus
- rid_err  out  1  sticky: beat arrived with rid != owner's ID

Behaviour:
- States: IDLE, AR_I, AR_D, R_I, R_D. Reset (rst=1 at a clk edge) forces IDLE, starve_cnt=0 and rid_err=0. This applies mid-burst too; a burst aborted this way is not resumed.
- Reset/idle outputs are 0: arvalid, rready, i_arready, d_arready, i_rvalid, d_rvalid, i_rlast, d_rlast. Data outputs are don't-care while their valids are low.
- IDLE decision is registered, giving one cycle of arbitration latency:
  - d_arvalid && !(i_arvalid && starve_cnt >= STARVE_LIMIT) -> AR_D.
  - else i_arvalid -> AR_I.
  - else stay IDLE.
- AR_x:
  - arvalid = x_arvalid; AR fields are taken from requester x; x_arready = arready.
  - arvalid && arready -> R_x.
  - If x_arvalid drops before the handshake -> IDLE, no transaction issued.
- R_x:
  - Bus R is routed combinationally: x_rvalid = rvalid, x_rdata = rdata, x_rlast = rlast, rready = x_rready.
  - The other requester sees rvalid=0.
  - rvalid && rready && rlast -> IDLE.
  - rvalid with rid != owner ID sets rid_err; the beat is still delivered.
- Starve counter:
  - Increments (saturating at 2^CNT_W-1) each cycle i_arvalid=1 and the arbiter is not in AR_I/R_I.
  - Clears on entering AR_I.
  - Holds when i_arvalid=0.
- A new request that arrives during R_x waits. The next grant is evaluated in the IDLE cycle after rlast, so there are no back-to-back AR handshakes (minimum one idle cycle between bursts).
- No outstanding-transaction overlap: at most one read in flight.

Decomposition:
- Shared package mem_arb_pkg holds:
  - typedef enum rd_arb_state_e {IDLE, AR_I, AR_D, R_I, R_D};
  - constants ID_ICACHE=4'd0, ID_DCACHE=4'd1, BURST_INCR=2'b01.
- One natural sub-module, starve_counter: saturating counter with inc/clr/hit outputs. It is reused later by the write-path arbiter.

Test Plan:
- Single i_cache burst: i_arvalid=1, araddr=0x1fc00000, arlen=3; bus returns 4 beats -> arid=0, i_rvalid pulses 4 times, i_rlast on beat 4, FSM back in IDLE the next cycle.
- Simultaneous requests: i_arvalid and d_arvalid rise together -> d_cache granted first (arid=1); i_cache AR issued one cycle after d rlast.
- Starvation: d_arvalid held high continuously with single-beat bursts while i_arvalid=1 -> i_cache is granted once starve_cnt reaches 8, no later.
- Backpressure: d_rready toggles 1,0,1,0 during a 4-beat burst -> rready mirrors d_rready, no beat lost or duplicated, i_rvalid stays 0.
- Reset mid-burst: rst=1 after beat 2 of 4 -> next cycle IDLE, arvalid=0, rready=0, starve_cnt=0, rid_err=0.
- Withdrawn request / ID error: i_arvalid drops while in AR_I with arready=0 -> IDLE, arvalid=0. Separately, rid=1 returned in R_I -> rid_err=1 and stays set until reset.
